alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencer that owns the shared 64-bit ALU and executes requests through a valid/ready handshake. It supports single ALU operations and a multi-cycle 64×64 multiply (low 64 bits), built as shift-and-add using only the ALU's ADD and SLL functions. It sits between the issue logic and the ALU instance, driving the ALU's operand and control inputs and capturing its result, so no dedicated multiplier is needed.

## Interface
Parameters: none. Width is fixed at 64; the iteration count is fixed at 64.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE with rst_n high
- req_op  in  1  0 = PASS (single ALU op), 1 = MUL
- req_ctrl  in  4  ALU control code for PASS; ignored for MUL
- req_a  in  64  operand A (multiplicand for MUL)
- req_b  in  64  operand B (multiplier for MUL)
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  result
- rsp_zero  out  1  rsp_result == 0
- busy  out  1  state != IDLE
- alu_a  out  64  ALU operand A
- alu_b  out  64  ALU operand B
- alu_ctrl  out  4  ALU control code
- alu_result  in  64  ALU combinational result

## Operation
- States: IDLE, PASS, MUL_ADD, MUL_SHIFT, DONE.
- Accept condition: req_valid && req_ready at a rising edge. Operands, op and ctrl are latched on that edge. Only one operation is in flight at a time.
- **PASS**
  - Drives alu_a = A, alu_b = B, alu_ctrl = ctrl.
  - Captures alu_result into rsp_result, then moves to DONE.
- **MUL**
  - Latched registers: acc = 0, mcand = A, mplier = B, cnt = 0 (7 bits).
  - From IDLE: go to MUL_ADD if B[0] = 1, else MUL_SHIFT.
  - MUL_ADD: drive A = acc, B = mcand, ctrl = 4'b0010; acc <= alu_result; go to MUL_SHIFT.
  - MUL_SHIFT: drive A = mcand, B = 1, ctrl = 4'b1000; mcand <= alu_result; mplier <= mplier >> 1 (local logic); cnt++.
  - After MUL_SHIFT: go to DONE if the termination condition holds. Otherwise go to MUL_ADD if the new mplier[0] = 1, else MUL_SHIFT.
  - On entering DONE: rsp_result <= acc.
  - Arithmetic is modulo 2^64. The result is identical for signed and unsigned operands.
- **DONE**
  - rsp_valid = 1; rsp_result and rsp_zero are stable.
  - On rsp_ready, return to IDLE.
  - No new request is accepted in the handshake cycle; req_ready rises the cycle after.
- In IDLE and DONE: alu_a = 0, alu_b = 0, alu_ctrl = 4'b0000.
- Reset: every output is 0 while rst_n is low (req_ready, rsp_valid, rsp_result, rsp_zero, busy, alu_*); state = IDLE. A reset mid-operation aborts the operation and produces no response.
- Unsupported req_ctrl codes in PASS are passed to the ALU unchanged (the ALU yields 0, so rsp_zero = 1).

## Timing
- With n execute cycles, rsp_valid is set at the n-th rising edge after the accept edge.
- PASS: n = 1.
- MUL without the macro: n = 64 + popcount(B).
- Throughput for PASS with rsp_ready tied high: one operation per 3 cycles (IDLE, PASS, DONE).
- rsp_ready held low: state stays DONE and all rsp_* outputs are held.
- req_valid asserted outside IDLE: ignored. The request must stay asserted until accepted.

## Configuration
- ALU_SEQ_EARLY_EXIT_EN
  - Defined: MUL terminates after MUL_SHIFT when the shifted mplier == 0. If B == 0 at accept, go straight to DONE with result 0 (n = 1). Otherwise n = (index of highest set bit of B + 1) + popcount(B).
  - Undefined: termination is cnt == 64 only, giving fixed, data-independent shift count.

## Structure
- Shared package alu_seq_pkg holds:
  - ALU control constants: ALU_AND 4'b0000, ALU_OR 4'b0001, ALU_ADD 4'b0010, ALU_XOR 4'b0100, ALU_SUB 4'b0110, ALU_SLL 4'b1000, ALU_SRL 4'b1001.
  - Op encodings OP_PASS / OP_MUL.
  - State enum.
- No sub-module: the ALU stays external so other masters can share it. The bench instantiates alu_seq_ctrl together with the ALU.

## Test plan
- PASS ADD, A=5, B=7, ctrl 0010 -> rsp_result=12, rsp_zero=0, rsp_valid at the 1st edge after accept.
- PASS SUB, A=B=0x1234, ctrl 0010→0110 -> rsp_result=0, rsp_zero=1. Also PASS SLL, A=1, B=63 -> 0x8000_0000_0000_0000.
- MUL 3×5 -> 15.
  - Macro undefined: n=66.
  - Macro defined: n=5.
  - MUL 7×0 with macro -> 0, n=1.
- MUL 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF -> 1, n=128 either way.
- Backpressure: rsp_ready low for 10 cycles -> rsp_valid=1, result stable, req_ready=0, busy=1. req_ready rises the cycle after rsp_ready.
- rst_n low for 1 edge at MUL cycle 10 -> next cycle all outputs 0, no response. A subsequent PASS XOR, A=0xF0, B=0xFF -> 0x0F.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared ALU control codes, op encodings and sequencer state type
package alu_seq_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   localparam logic OP_PASS = 1'b0;
   localparam logic OP_MUL  = 1'b1;

   localparam int         DATA_W    = 64;
   localparam logic [6:0] MUL_ITERS = 7'd64;

   typedef enum logic [2:0] {
      IDLE,
      PASS,
      MUL_ADD,
      MUL_SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - shared-ALU sequencer for single ops and shift-add multiply (option: ALU_SEQ_EARLY_EXIT_EN)
module alu_seq_ctrl
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [3:0]        req_ctrl,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              busy,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_result
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q;        // PASS operand A, or running multiplicand
   logic [DATA_W-1:0] b_q;        // PASS operand B, or remaining multiplier bits
   logic [3:0]        ctrl_q;
   logic [DATA_W-1:0] acc_q;
   logic [6:0]        cnt_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;

   logic [DATA_W-1:0] mplier_shr;
   logic [6:0]        cnt_inc;
   logic              mul_last;
   logic              accept;
   logic              mul_b_zero;
   logic [DATA_W-1:0] alu_a_d, alu_b_d;
   logic [3:0]        alu_ctrl_d;

   assign mplier_shr = b_q >> 1;
   assign cnt_inc    = cnt_q + 7'd1;
   assign accept     = req_valid && req_ready;

`ifdef ALU_SEQ_EARLY_EXIT_EN
   // Stop once no multiplier bits remain; the count bound is implied but kept as a backstop.
   assign mul_last   = (mplier_shr == '0) || (cnt_inc == MUL_ITERS);
   assign mul_b_zero = (req_b == '0);
`else
   assign mul_last   = (cnt_inc == MUL_ITERS);
   assign mul_b_zero = 1'b0;
`endif

   // Outputs are forced low while reset is asserted, even before the first reset edge.
   assign req_ready  = rst_n && (state_q == IDLE);
   assign rsp_valid  = rst_n && (state_q == DONE);
   assign busy       = rst_n && (state_q != IDLE);
   assign rsp_result = rst_n ? result_q : '0;
   assign rsp_zero   = rst_n && zero_q;
   assign alu_a      = rst_n ? alu_a_d : '0;
   assign alu_b      = rst_n ? alu_b_d : '0;
   assign alu_ctrl   = rst_n ? alu_ctrl_d : 4'b0000;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state selection and ALU operand steering.
   always_comb begin
      state_d    = state_q;
      alu_a_d    = '0;
      alu_b_d    = '0;
      alu_ctrl_d = ALU_AND;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_op == OP_MUL) begin
                  if (mul_b_zero)    state_d = DONE;
                  else if (req_b[0]) state_d = MUL_ADD;
                  else               state_d = MUL_SHIFT;
               end else begin
                  state_d = PASS;
               end
            end
         end
         PASS: begin
            alu_a_d    = a_q;
            alu_b_d    = b_q;
            alu_ctrl_d = ctrl_q;
            state_d    = DONE;
         end
         MUL_ADD: begin
            alu_a_d    = acc_q;
            alu_b_d    = a_q;
            alu_ctrl_d = ALU_ADD;
            state_d    = MUL_SHIFT;
         end
         MUL_SHIFT: begin
            alu_a_d    = a_q;
            alu_b_d    = 64'd1;
            alu_ctrl_d = ALU_SLL;
            if (mul_last)           state_d = DONE;
            else if (mplier_shr[0]) state_d = MUL_ADD;
            else                    state_d = MUL_SHIFT;
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latching, accumulation and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= 4'b0000;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q    <= req_a;
                  b_q    <= req_b;
                  ctrl_q <= req_ctrl;
                  acc_q  <= '0;
                  cnt_q  <= '0;
                  if (req_op == OP_MUL && mul_b_zero) begin
                     result_q <= '0;
                     zero_q   <= 1'b1;
                  end
               end
            end
            PASS: begin
               result_q <= alu_result;
               zero_q   <= (alu_result == '0);
            end
            MUL_ADD: begin
               acc_q <= alu_result;
            end
            MUL_SHIFT: begin
               a_q   <= alu_result;
               b_q   <= mplier_shr;
               cnt_q <= cnt_inc;
               if (mul_last) begin
                  result_q <= acc_q;
                  zero_q   <= (acc_q == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with a behavioural ALU (option: ALU_SEQ_EARLY_EXIT_EN)
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_op;
   logic [3:0]  req_ctrl;
   logic [63:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_zero, busy;
   logic [63:0] rsp_result, alu_a, alu_b, alu_result;
   logic [3:0]  alu_ctrl;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int accept_cycle = 0;

   typedef struct {
      logic [63:0] res;
      logic        zero;
      int          n;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        op;
      logic [3:0]  ctrl;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
   } vec_t;
   vec_t tbl[12];

   alu_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used for throughput measurement.
   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural model of the shared ALU.
   always_comb begin
      alu_result = 64'd0;
      case (alu_ctrl)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0100: alu_result = alu_a ^ alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b1000: alu_result = alu_a << alu_b[5:0];
         4'b1001: alu_result = alu_a >> alu_b[5:0];
         default: alu_result = 64'd0;
      endcase
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%016h expected=0x%016h", nm, act, exp);
      end
   endtask

   function automatic int exp_n(input logic op, input logic [63:0] b);
      int pc;
      int hb;
      if (op == 1'b0) return 1;
      pc = $countones(b);
`ifdef ALU_SEQ_EARLY_EXIT_EN
      if (b == 64'd0) return 1;
      hb = 0;
      for (int i = 0; i < 64; i++) if (b[i]) hb = i;
      return hb + 1 + pc;
`else
      hb = 0;
      return 64 + pc + hb;
`endif
   endfunction

   task automatic send(input logic op, input logic [3:0] ctrl, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res);
      exp_t e;
      int   w;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_ctrl = ctrl; req_a = a; req_b = b;
      w = 0;
      while (!req_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_ready_timeout actual=0 expected=1");
      end
      @(posedge clk);
      accept_cycle = cycle;
      e.res = res; e.zero = (res == 64'd0); e.n = exp_n(op, b);
      sb.push_back(e);
      #1 req_valid = 1'b0;
   endtask

   task automatic recv(input string nm, input int hold);
      exp_t        e;
      int          n;
      logic [63:0] held;
      e = sb.pop_front();
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!rsp_valid && n < 400);
      chk({nm, "_latency"}, 64'(n), 64'(e.n));
      chk({nm, "_result"}, rsp_result, e.res);
      chk({nm, "_zero"}, 64'(rsp_zero), 64'(e.zero));
      held = rsp_result;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk({nm, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({nm, "_hold_result"}, rsp_result, held);
         chk({nm, "_hold_req_ready"}, 64'(req_ready), 64'd0);
         chk({nm, "_hold_busy"}, 64'(busy), 64'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({nm, "_post_valid"}, 64'(rsp_valid), 64'd0);
      chk({nm, "_post_req_ready"}, 64'(req_ready), 64'd1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({nm, "_rsp_result"}, rsp_result, 64'd0);
      chk({nm, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_alu_a"}, alu_a, 64'd0);
      chk({nm, "_alu_b"}, alu_b, 64'd0);
      chk({nm, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb;
      int          c0;
      string       nm;

      tbl[0]  = '{1'b0, 4'b0010, 64'd5, 64'd7, 64'd12};
      tbl[1]  = '{1'b0, 4'b0110, 64'h1234, 64'h1234, 64'd0};
      tbl[2]  = '{1'b0, 4'b1000, 64'd1, 64'd63, 64'h8000_0000_0000_0000};
      tbl[3]  = '{1'b0, 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000};
      tbl[4]  = '{1'b0, 4'b0001, 64'hF0, 64'h0F, 64'hFF};
      tbl[5]  = '{1'b0, 4'b1001, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
      tbl[6]  = '{1'b0, 4'b1111, 64'hABC, 64'd1, 64'd0};
      tbl[7]  = '{1'b1, 4'b0000, 64'd3, 64'd5, 64'd15};
      tbl[8]  = '{1'b1, 4'b0000, 64'd7, 64'd0, 64'd0};
      tbl[9]  = '{1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
      tbl[10] = '{1'b1, 4'b0000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
      tbl[11] = '{1'b1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB};

      rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_ctrl = 4'd0;
      req_a = 64'd0; req_b = 64'd0; rsp_ready = 1'b0;
      #1 chk_all_zero("reset_async_view");
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      #1 chk("idle_req_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 12; i++) begin
         nm = $sformatf("vec%0d", i);
         send(tbl[i].op, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].res);
         recv(nm, 0);
      end

      for (int i = 0; i < 4; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(0, 60);
         send(1'b1, 4'b0000, ra, rb, ra * rb);
         recv($sformatf("rand_mul%0d", i), 0);
      end

      send(1'b0, 4'b0100, 64'h0F0F, 64'hFFFF, 64'hF0F0);
      c0 = accept_cycle;
      recv("tput_a", 0);
      send(1'b0, 4'b0010, 64'd1, 64'd1, 64'd2);
      chk("throughput_cycles", 64'(accept_cycle - c0), 64'd3);
      recv("tput_b", 0);

      send(1'b0, 4'b0010, 64'd100, 64'd23, 64'd123);
      recv("backpressure", 10);

      send(1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      repeat (10) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1 chk_all_zero("abort");
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
      end
      send(1'b0, 4'b0100, 64'hF0, 64'hFF, 64'h0F);
      recv("post_abort_xor", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
